// File: rtl/dm_cache_controller.sv
// ---------------------------------------------------------------------------
// dm_cache_controller
//
// Direct-mapped, write-back, write-allocate cache controller. It sits
// between a CPU load/store port and a 128-bit-line main memory. The block
// holds the tag/valid/dirty state and the line storage itself, and it stalls
// the CPU on a miss. It drives the memory en_read/en_write/ack handshake as
// the initiator.
//
// Optional build macro: CACHE_STATS_EN. When defined, the block adds the
// hit_count and miss_count outputs.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   cpu_addr        byte address ([3:2] selects the word, [1:0] is ignored)
//   cpu_wdata       store data
//   cpu_read        load request, held until cpu_ready
//   cpu_write       store request, held until cpu_ready (wins over cpu_read)
//   cpu_rdata       load data, valid while cpu_ready is high
//   cpu_ready       one-cycle completion strobe
//   mem_addr        line address {tag, index, 4'b0}
//   mem_wdata       victim line for a write-back
//   mem_en_read     line fill request
//   mem_en_write    line write-back request
//   mem_rdata       fill data from memory
//   mem_ack         memory completion
//   hit_count       (CACHE_STATS_EN only) count of first-look hits
//   miss_count      (CACHE_STATS_EN only) count of first-look misses
// ---------------------------------------------------------------------------
module dm_cache_controller #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [127:0]      mem_wdata,
    output logic              mem_en_read,
    output logic              mem_en_write,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        WB_RELEASE,
        ALLOCATE,
        FILL_RELEASE,
        DONE
    } state_t;

    state_t state, next_state;

    // Latched request. The byte-offset bits are never stored.
    logic [ADDR_W-1:2] req_addr;
    logic [31:0]       req_wdata;
    logic              req_write;
    // Set once a fill has completed, so the re-run of COMPARE is not counted
    // as a second lookup.
    logic              retry;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [127:0]      line_mem [LINES];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [6:0]            word_lsb;
    logic [127:0]          cur_line;
    logic [TAG_W-1:0]      cur_tag;
    logic                  hit;
    logic                  victim_dirty;
    logic                  unused_addr_bits;

    assign req_tag          = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx          = req_addr[4 +: INDEX_BITS];
    assign word_lsb         = {req_addr[3:2], 5'd0};
    assign cur_line         = line_mem[req_idx];
    assign cur_tag          = tag_mem[req_idx];
    assign hit              = valid[req_idx] && (cur_tag == req_tag);
    assign victim_dirty     = valid[req_idx] && dirty[req_idx];
    assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request capture, load data and the per-line valid/dirty flags. A reset
    // invalidates every line, so a write-back that was in flight is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_write <= 1'b0;
            retry     <= 1'b0;
            cpu_rdata <= '0;
            valid     <= '0;
            dirty     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_read || cpu_write) begin
                        req_addr  <= cpu_addr[ADDR_W-1:2];
                        req_wdata <= cpu_wdata;
                        req_write <= cpu_write;
                        retry     <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_write) begin
                            dirty[req_idx] <= 1'b1;
                        end else begin
                            cpu_rdata <= cur_line[word_lsb +: 32];
                        end
                    end
                end
                ALLOCATE: begin
                    if (mem_ack) begin
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                    end
                end
                FILL_RELEASE: begin
                    if (!mem_ack) begin
                        retry <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line and tag storage. These need no reset because the valid bits
    // qualify them. A fill writes the whole line on its ack edge, so an
    // interrupted fill leaves no partial state behind.
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_write) begin
            line_mem[req_idx][word_lsb +: 32] <= req_wdata;
        end
        if (state == ALLOCATE && mem_ack) begin
            line_mem[req_idx] <= mem_rdata;
            tag_mem[req_idx]  <= req_tag;
        end
    end

    // Next state and outputs. The memory requests and their address/data
    // come straight from the state register. They drop as soon as reset
    // forces IDLE, and they stay stable for as long as a request is held.
    always_comb begin
        next_state   = state;
        cpu_ready    = 1'b0;
        mem_en_read  = 1'b0;
        mem_en_write = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    next_state = DONE;
                end else if (victim_dirty) begin
                    next_state = WRITEBACK;
                end else begin
                    next_state = ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_en_write = 1'b1;
                mem_addr     = {cur_tag, req_idx, 4'b0000};
                mem_wdata    = cur_line;
                if (mem_ack) begin
                    next_state = WB_RELEASE;
                end
            end
            WB_RELEASE: begin
                if (!mem_ack) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_en_read = 1'b1;
                mem_addr    = {req_tag, req_idx, 4'b0000};
                if (mem_ack) begin
                    next_state = FILL_RELEASE;
                end
            end
            FILL_RELEASE: begin
                if (!mem_ack) begin
                    next_state = COMPARE;
                end
            end
            DONE: begin
                cpu_ready  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    // Only the first lookup of each request is classified. Both counters
    // wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == COMPARE && !retry) begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_controller.sv
`timescale 1ns/1ps
module tb_dm_cache_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_en_read;
    logic         mem_en_write;
    logic [127:0] mem_rdata;
    logic         mem_ack;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    always #5 clk = ~clk;

    dm_cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_en_read  (mem_en_read),
        .mem_en_write (mem_en_write),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [127:0] data;
    } txn_t;

    // Main memory seen by the responder, plus a log of completed transactions.
    logic [127:0] store [logic [31:0]];
    txn_t         txn_log[$];
    bit           hold_ack = 1'b0;

    // Reference model: abstract cache contents plus its own view of memory.
    bit           m_valid [64];
    bit           m_dirty [64];
    logic [21:0]  m_tag   [64];
    logic [127:0] m_line  [64];
    logic [127:0] model_mem [logic [31:0]];

    function automatic logic [127:0] default_line(input logic [31:0] a);
        return {a ^ 32'hC3C3_0003, a ^ 32'h8181_0002, a ^ 32'h4242_0001, a ^ 32'h2424_0000};
    endfunction

    function automatic logic [127:0] store_get(input logic [31:0] a);
        if (store.exists(a)) return store[a];
        return default_line(a);
    endfunction

    function automatic logic [127:0] model_get(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return default_line(a);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic preload(input logic [31:0] line_addr, input logic [127:0] data);
        store[line_addr]     = data;
        model_mem[line_addr] = data;
    endtask

    // Cache semantics: returns what the CPU sees and the memory traffic the op
    // must cause.
    task automatic model_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] exp_rdata, output bit exp_hit, output bit exp_wb,
                            output logic [31:0] exp_wb_addr, output logic [127:0] exp_wb_data);
        int          idx;
        int          w;
        logic [21:0] tag;
        idx         = int'(addr[9:4]);
        w           = int'(addr[3:2]);
        tag         = addr[31:10];
        exp_hit     = m_valid[idx] && (m_tag[idx] == tag);
        exp_wb      = 1'b0;
        exp_wb_addr = '0;
        exp_wb_data = '0;
        exp_rdata   = '0;
        if (!exp_hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_wb                 = 1'b1;
                exp_wb_addr            = {m_tag[idx], addr[9:4], 4'b0000};
                exp_wb_data            = m_line[idx];
                model_mem[exp_wb_addr] = m_line[idx];
            end
            m_line[idx]  = model_get({addr[31:4], 4'b0000});
            m_tag[idx]   = tag;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_line[idx][w*32 +: 32] = wdata;
            m_dirty[idx]            = 1'b1;
        end else begin
            exp_rdata = m_line[idx][w*32 +: 32];
        end
    endtask

    // Memory responder with random latency. It also checks the handshake
    // rules on every cycle.
    initial begin : responder
        int           lat;
        bit           prev_req;
        bit           cur_wr;
        logic [31:0]  cur_addr;
        logic [127:0] cur_wdata;
        txn_t         t;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        lat       = 0;
        prev_req  = 1'b0;
        cur_wr    = 1'b0;
        cur_addr  = '0;
        cur_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack  = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (mem_en_read && mem_en_write) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL mem_both_req actual=1 required=0");
                end
                if (mem_en_read || mem_en_write) begin
                    if (!prev_req) begin
                        total++;
                        if (mem_ack) begin
                            bad++;
                            $display("[TB] FAIL mem_reraise_under_ack actual_ack=1 required=0");
                        end
                        cur_wr    = mem_en_write;
                        cur_addr  = mem_addr;
                        cur_wdata = mem_wdata;
                        lat       = $urandom_range(1, 4);
                    end else begin
                        total++;
                        if (mem_addr !== cur_addr || mem_en_write !== cur_wr ||
                            (mem_en_write && mem_wdata !== cur_wdata)) begin
                            bad++;
                            $display("[TB] FAIL mem_req_stable actual_addr=%h wr=%0b required_addr=%h wr=%0b",
                                     mem_addr, mem_en_write, cur_addr, cur_wr);
                        end
                    end
                    if (!mem_ack) begin
                        if (lat > 0) lat--;
                        if (lat == 0 && !hold_ack) begin
                            mem_ack = 1'b1;
                            t.wr    = mem_en_write;
                            t.addr  = mem_addr;
                            if (mem_en_write) begin
                                store[mem_addr] = mem_wdata;
                                t.data          = mem_wdata;
                            end else begin
                                mem_rdata = store_get(mem_addr);
                                t.data    = mem_rdata;
                            end
                            txn_log.push_back(t);
                        end
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                prev_req = mem_en_read || mem_en_write;
            end
        end
    end

    // Runs one CPU op. Inputs change at negedges, and the address/data lines
    // are scrambled while the request waits, so the latched values get used.
    task automatic cpu_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int cycles, output int pulses,
                          output bit timed_out);
        txn_log.delete();
        @(negedge clk);
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_write = wr;
        cpu_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        cycles    = 0;
        pulses    = 0;
        timed_out = 1'b1;
        rdata     = '0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cpu_ready) begin
                rdata     = cpu_rdata;
                timed_out = 1'b0;
                pulses    = 1;
                break;
            end
            cpu_addr  = $urandom();
            cpu_wdata = $urandom();
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        if (cpu_ready) pulses++;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_cpu_ready actual=%b required=0", cpu_ready); end
        total++;
        if (cpu_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_cpu_rdata actual=%h required=0", cpu_rdata); end
        total++;
        if ({mem_en_read, mem_en_write} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_mem_req actual=%b required=00", {mem_en_read, mem_en_write});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin
            bad++; $display("[TB] FAIL reset_mem_bus actual=%h/%h required=0", mem_addr, mem_wdata);
        end
`ifdef CACHE_STATS_EN
        total++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_stats actual=%0d/%0d required=0/0", hit_count, miss_count);
        end
`endif
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_cold_read();
        logic [31:0] rd, e_rd, e_wba; logic [127:0] e_wbd; bit e_hit, e_wb, to; int cyc, pulses;
        preload(32'h0000_0100, 128'h4444_4444_3333_3333_DDDD_CCCC_BBBB_AAAA);
        model_op(1'b0, 32'h0000_0104, 32'h0, e_rd, e_hit, e_wb, e_wba, e_wbd);
        cpu_op(1'b0, 32'h0000_0104, 32'h0, rd, cyc, pulses, to);
        total++;
        if (to || rd !== 32'hDDDD_CCCC) begin bad++; $display("[TB] FAIL cold_rdata actual=%h timeout=%0b required=ddddcccc", rd, to); end
        total++;
        if (txn_log.size() != 1) begin
            bad++; $display("[TB] FAIL cold_txn_count actual=%0d required=1", txn_log.size());
        end else if (txn_log[0].wr || txn_log[0].addr !== 32'h0000_0100) begin
            bad++; $display("[TB] FAIL cold_fill actual=wr%0b@%h required=rd@00000100", txn_log[0].wr, txn_log[0].addr);
        end
        total++;
        if (pulses != 1) begin bad++; $display("[TB] FAIL cold_ready_pulses actual=%0d required=1", pulses); end
    endtask

    task automatic test_repeat_read();
        logic [31:0] rd, e_rd, e_wba; logic [127:0] e_wbd; bit e_hit, e_wb, to; int cyc, pulses;
        model_op(1'b0, 32'h0000_0104, 32'h0, e_rd, e_hit, e_wb, e_wba, e_wbd);
        cpu_op(1'b0, 32'h0000_0104, 32'h0, rd, cyc, pulses, to);
        total++;
        if (to || cyc != 2) begin bad++; $display("[TB] FAIL hit_latency actual=%0d timeout=%0b required=2", cyc, to); end
        total++;
        if (rd !== 32'hDDDD_CCCC || txn_log.size() != 0) begin
            bad++; $display("[TB] FAIL hit_read actual=%h txns=%0d required=ddddcccc txns=0", rd, txn_log.size());
        end
    endtask

    task automatic test_writeback_conflict();
        logic [31:0] rd, e_rd, e_wba; logic [127:0] e_wbd; bit e_hit, e_wb, to; int cyc, pulses;
        model_op(1'b1, 32'h0000_0108, 32'h1234_5678, e_rd, e_hit, e_wb, e_wba, e_wbd);
        cpu_op(1'b1, 32'h0000_0108, 32'h1234_5678, rd, cyc, pulses, to);
        total++;
        if (to || cyc != 2 || txn_log.size() != 0) begin
            bad++; $display("[TB] FAIL write_hit actual=cyc%0d txns=%0d required=cyc2 txns=0", cyc, txn_log.size());
        end
        model_op(1'b0, 32'h0000_1108, 32'h0, e_rd, e_hit, e_wb, e_wba, e_wbd);
        cpu_op(1'b0, 32'h0000_1108, 32'h0, rd, cyc, pulses, to);
        total++;
        if (txn_log.size() != 2) begin
            bad++; $display("[TB] FAIL conflict_txn_count actual=%0d required=2", txn_log.size());
        end else begin
            if (!txn_log[0].wr || txn_log[0].addr !== 32'h0000_0100 ||
                txn_log[0].data !== 128'h4444_4444_1234_5678_DDDD_CCCC_BBBB_AAAA) begin
                bad++; $display("[TB] FAIL conflict_wb actual=wr%0b@%h %h required=wr1@00000100 444444441234567 8ddddccccbbbbaaaa",
                                txn_log[0].wr, txn_log[0].addr, txn_log[0].data);
            end
            total++;
            if (txn_log[1].wr || txn_log[1].addr !== 32'h0000_1100) begin
                bad++; $display("[TB] FAIL conflict_fill actual=wr%0b@%h required=rd@00001100", txn_log[1].wr, txn_log[1].addr);
            end
        end
        total++;
        if (to || rd !== default_line(32'h0000_1100)[95:64]) begin
            bad++; $display("[TB] FAIL conflict_rdata actual=%h required=%h", rd, default_line(32'h0000_1100)[95:64]);
        end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd, e_rd, e_wba; logic [127:0] e_wbd, exp_line; bit e_hit, e_wb, to; int cyc, pulses;
        model_op(1'b1, 32'h0000_2000, 32'hCAFE_F00D, e_rd, e_hit, e_wb, e_wba, e_wbd);
        cpu_op(1'b1, 32'h0000_2000, 32'hCAFE_F00D, rd, cyc, pulses, to);
        total++;
        if (to || txn_log.size() != 1 || txn_log[0].wr || txn_log[0].addr !== 32'h0000_2000) begin
            bad++; $display("[TB] FAIL write_miss_fill actual=txns%0d timeout=%0b required=one fill of 00002000", txn_log.size(), to);
        end
        exp_line        = default_line(32'h0000_2000);
        exp_line[31:0]  = 32'hCAFE_F00D;
        model_op(1'b0, 32'h0000_3000, 32'h0, e_rd, e_hit, e_wb, e_wba, e_wbd);
        cpu_op(1'b0, 32'h0000_3000, 32'h0, rd, cyc, pulses, to);
        total++;
        if (txn_log.size() != 2 || !txn_log[0].wr || txn_log[0].addr !== 32'h0000_2000 ||
            txn_log[0].data !== exp_line || txn_log[1].wr || txn_log[1].addr !== 32'h0000_3000) begin
            bad++; $display("[TB] FAIL write_miss_wb actual=txns%0d required=wb 00002000 %h then fill 00003000", txn_log.size(), exp_line);
        end
        total++;
        if (to || rd !== 32'h2424_3000) begin bad++; $display("[TB] FAIL write_miss_rdata actual=%h required=24243000", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, e_rd, e_wba; logic [127:0] e_wbd; bit e_hit, e_wb, to, seen; int cyc, pulses;
        hold_ack = 1'b1;
        @(negedge clk);
        cpu_addr  = 32'h0000_4040;
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en_read) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL reset_mid_alloc actual=no_en_read required=en_read"); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (mem_en_read !== 1'b0 || cpu_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_mid_drop actual=rd%b rdy%b required=0 0", mem_en_read, cpu_ready);
        end
        cpu_read = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        hold_ack = 1'b0;
        model_clear();
        model_op(1'b0, 32'h0000_4040, 32'h0, e_rd, e_hit, e_wb, e_wba, e_wbd);
        cpu_op(1'b0, 32'h0000_4040, 32'h0, rd, cyc, pulses, to);
        total++;
        if (to || txn_log.size() != 1 || txn_log[0].wr || txn_log[0].addr !== 32'h0000_4040 || rd !== e_rd) begin
            bad++; $display("[TB] FAIL reset_mid_remiss actual=txns%0d rd=%h required=one fill rd=%h", txn_log.size(), rd, e_rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, e_rd, e_wba, addr, wd; logic [127:0] e_wbd; bit e_hit, e_wb, to, wr;
        int cyc, pulses, n_exp, k;
        logic [21:0] tags [4];
        int          idxs [3];
        tags[0] = 22'h0; tags[1] = 22'h1; tags[2] = 22'h2AAAA; tags[3] = 22'h3FFFFF;
        idxs[0] = 0; idxs[1] = 1; idxs[2] = 63;
        for (int n = 0; n < 150; n++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = {tags[$urandom_range(0, 3)], 6'(idxs[$urandom_range(0, 2)]), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            wd   = $urandom();
            model_op(wr, addr, wd, e_rd, e_hit, e_wb, e_wba, e_wbd);
            cpu_op(wr, addr, wd, rd, cyc, pulses, to);
            total++;
            if (to) begin
                bad++; $display("[TB] FAIL rand_timeout op=%0d addr=%h actual=no_ready required=ready", n, addr);
            end else begin
                n_exp = (e_hit ? 0 : 1) + (e_wb ? 1 : 0);
                if (!wr && rd !== e_rd) begin
                    bad++; $display("[TB] FAIL rand_rdata op=%0d addr=%h actual=%h required=%h", n, addr, rd, e_rd);
                end else if (pulses != 1) begin
                    bad++; $display("[TB] FAIL rand_pulses op=%0d actual=%0d required=1", n, pulses);
                end else if (e_hit && cyc != 2) begin
                    bad++; $display("[TB] FAIL rand_hit_latency op=%0d actual=%0d required=2", n, cyc);
                end else if (txn_log.size() != n_exp) begin
                    bad++; $display("[TB] FAIL rand_txn_count op=%0d addr=%h actual=%0d required=%0d", n, addr, txn_log.size(), n_exp);
                end else begin
                    k = 0;
                    if (e_wb) begin
                        if (!txn_log[0].wr || txn_log[0].addr !== e_wba || txn_log[0].data !== e_wbd) begin
                            bad++; $display("[TB] FAIL rand_wb op=%0d actual=%h %h required=%h %h",
                                            n, txn_log[0].addr, txn_log[0].data, e_wba, e_wbd);
                        end
                        k = 1;
                    end
                    if (!e_hit && (txn_log[k].wr || txn_log[k].addr !== {addr[31:4], 4'b0000})) begin
                        bad++; $display("[TB] FAIL rand_fill op=%0d actual=wr%0b@%h required=rd@%h",
                                        n, txn_log[k].wr, txn_log[k].addr, {addr[31:4], 4'b0000});
                    end
                end
            end
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] rd, e_rd, e_wba, h0, m0; logic [127:0] e_wbd; bit e_hit, e_wb, to; int cyc, pulses;
        logic [31:0] seq_addr [4];
        bit          seq_wr   [4];
        seq_addr[0] = 32'h5000_0010; seq_wr[0] = 1'b0;
        seq_addr[1] = 32'h5000_0014; seq_wr[1] = 1'b0;
        seq_addr[2] = 32'h5000_0018; seq_wr[2] = 1'b1;
        seq_addr[3] = 32'h6000_0010; seq_wr[3] = 1'b0;
        @(negedge clk);
        h0 = hit_count;
        m0 = miss_count;
        for (int i = 0; i < 4; i++) begin
            model_op(seq_wr[i], seq_addr[i], 32'hABCD_0000 + 32'(i), e_rd, e_hit, e_wb, e_wba, e_wbd);
            cpu_op(seq_wr[i], seq_addr[i], 32'hABCD_0000 + 32'(i), rd, cyc, pulses, to);
        end
        total++;
        if (hit_count - h0 !== 32'd2 || miss_count - m0 !== 32'd2) begin
            bad++; $display("[TB] FAIL stats_counts actual=hit%0d miss%0d required=hit2 miss2", hit_count - h0, miss_count - m0);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_cold_read();
        test_repeat_read();
        test_writeback_conflict();
        test_write_miss();
        test_reset_mid();
        test_random();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog actual=still_running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dm_cache_controller.md
Name: dm_cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache controller.
- Sits between the CPU load/store port and the 128-bit main memory block.
- Acts as the initiator of the main memory en_read/en_write/ram_ack handshake.
- Holds tag/valid/dirty state and 128-bit line storage internally; stalls the CPU on misses.

Parameters:
- INDEX_BITS, 6: line index width; 2^INDEX_BITS lines. Tag width = 28-INDEX_BITS.
- ADDR_W, 32: byte address width. Fixed at 32; any other value is unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  32  byte address. [3:2] word select, [1:0] ignored.
- cpu_wdata  in  32  store data
- cpu_read  in  1  load request; held until cpu_ready
- cpu_write  in  1  store request; held until cpu_ready; wins if cpu_read is also high
- cpu_rdata  out  32  load data; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion strobe
- mem_addr  out  32  line address {tag,index,4'b0}
- mem_wdata  out  128  write-back line, driven to the memory data_in
- mem_en_read  out  1  line fill request
- mem_en_write  out  1  line write-back request
- mem_rdata  in  128  fill data from the memory data_out
- mem_ack  in  1  memory completion (ram_ack)

Behaviour:
- Reset (async): all valid and dirty bits cleared; state=IDLE; all outputs 0. Line data contents are don't-care.
- State machine: IDLE, COMPARE, WRITEBACK, WB_RELEASE, ALLOCATE, FILL_RELEASE, DONE.
- IDLE: on (cpu_read|cpu_write), latch addr, wdata and op; go to COMPARE.
- COMPARE: hit = valid[idx] & tag match.
  - Read hit: latch the selected word into cpu_rdata; go to DONE.
  - Write hit: update the word; set dirty; go to DONE.
  - Miss with valid & dirty victim: go to WRITEBACK.
  - Otherwise: go to ALLOCATE.
- WRITEBACK: mem_en_write=1, mem_addr={victim tag,idx,0}, mem_wdata=victim line; hold until mem_ack=1. Then drop mem_en_write and go to WB_RELEASE.
- WB_RELEASE: all requests low; wait for mem_ack=0; go to ALLOCATE.
- ALLOCATE: mem_en_read=1, mem_addr={req tag,idx,0}; hold until mem_ack=1.
  - On the ack edge, capture mem_rdata into the line; set tag, valid=1, dirty=0.
  - Drop mem_en_read; go to FILL_RELEASE.
- FILL_RELEASE: wait for mem_ack=0; go to COMPARE. The retry hits, and a store then merges its word and sets dirty.
- DONE: cpu_ready=1 for exactly this cycle; go to IDLE. The CPU drops its request on the same edge. IDLE always needs one cycle before accepting again.
- Memory-side rules:
  - mem_addr and mem_wdata stay stable for the whole time a request is high.
  - mem_en_read and mem_en_write are never high together.
  - A request is never re-raised while mem_ack=1.
- Latency (request high to cpu_ready high): hit = 2 cycles. A miss adds the memory latency plus one release cycle per memory transaction.
- Index wrap: line address arithmetic is pure concatenation; no carries.
- CPU request changes while busy are ignored; latched values are used.
- Reset mid-transaction: memory requests drop immediately. An in-flight write-back is lost and the line becomes invalid. No partial update is permitted.
- mem_ack=1 seen in IDLE, COMPARE or DONE is ignored.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Each counts the first COMPARE of a request only; a post-fill retry is not counted.
  - Both cleared by rst; both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Cold read at 0x0000_0104, memory line 0x10 = 128'h...DDDD_CCCC_BBBB_AAAA.
  - Requires exactly one mem_en_read with mem_addr=0x0000_0100 and no write-back.
  - cpu_rdata=0x....CCCC; cpu_ready pulses once.
- Repeat read of 0x0000_0104: cpu_ready 2 cycles after the request; no memory activity.
- Write 0x1234_5678 to 0x0000_0108 (hit), then read 0x0000_1108 (same index 0x10, different tag).
  - Requires a write-back to 0x0000_0100 with word 2 = 0x1234_5678, then a read of 0x0000_1100.
  - The write-back request must be dropped before the read is raised.
- Write miss to 0x0000_2000 on an invalid line: a fill only, then the line is dirty. A later conflicting miss to 0x0000_3000 must write back 0x0000_2000.
- Assert rst during ALLOCATE while mem_ack=0:
  - mem_en_read drops asynchronously; cpu_ready stays 0.
  - A following read of the same address misses again.
- With CACHE_STATS_EN: a sequence of miss, hit, hit, miss gives hit_count=2 and miss_count=2.
